sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised pixel compositor that replaces fixed per-object colour selection with an N-layer, priority-ordered, palette-driven pixel pipeline. It sits between the sprite ROM/position logic (which supplies a per-layer hit flag, 2-bit colour index and palette select for the current DrawX/DrawY) and the VGA DAC outputs. It adds:
- a CPU-writable palette;
- per-layer blinking driven by a frame counter;
- a programmable background colour;
- a fixed-latency registered RGB output.

## Interface
Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority.
- IDX_W, 2, colour index width per layer; index 0 is transparent.
- PSEL_W, 2, palette-select width; palette RAM holds 2^(PSEL_W+IDX_W) entries.
- COLOR_W, 8, bits per colour channel.
- BLINK_FRAMES, 16, frames per blink half-period; must be ≥1.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- pixel_valid  in  1  qualifies the layer inputs for the current pixel.
- layer_hit  in  NUM_LAYERS  per-layer "sprite covers this pixel".
- layer_idx  in  NUM_LAYERS*IDX_W  per-layer colour index; layer k occupies bits [k*IDX_W +: IDX_W].
- layer_psel  in  NUM_LAYERS*PSEL_W  per-layer palette select, packed the same way.
- blink_mask  in  NUM_LAYERS  layers subject to blinking.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- pal_we  in  1  palette write strobe.
- pal_waddr  in  PSEL_W+IDX_W  palette write address, {psel, idx}.
- pal_wdata  in  3*COLOR_W  palette write data, {R,G,B}.
- bg_we  in  1  background colour write strobe.
- bg_wdata  in  3*COLOR_W  background colour, {R,G,B}.
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  composited colour.
- rgb_valid  out  1  VGA_* hold the result for a valid pixel.

## Operation
Reset (Reset_n low, asynchronous):
- All palette entries, background register, frame counter and blink_phase clear to 0.
- All pipeline registers, VGA_* and rgb_valid clear to 0.
- On release, the first pixel_valid produces a result after the standard latency.

Frame counter:
- Width is clog2(BLINK_FRAMES), minimum 1 bit. It increments on each frame_start.
- When the counter equals BLINK_FRAMES-1 on a frame_start, it wraps to 0 and blink_phase toggles.
- The new blink_phase applies from the cycle after frame_start, including a pixel presented in that same cycle.

Stage 1 (select):
- A layer k is eligible when layer_hit[k]=1, layer_idx[k]≠0, and !(blink_mask[k] && blink_phase).
- Winner = lowest-numbered eligible layer. Register {psel_k, idx_k} as the palette address, plus a `use_bg` flag (set when no layer is eligible) and valid.

Stage 2 (lookup):
- Registered read of palette[addr], or of the background register when use_bg=1. Valid is carried along.

Stage 3 (output):
- VGA_* ← looked-up colour when valid, else 0 (blanking). rgb_valid ← valid.

Writes:
- pal_we writes palette[pal_waddr] at the clock edge.
- A stage-2 read of the same address in the same cycle returns the old value (read-first). The new value is seen by the next pixel.
- bg_we follows the same rule. pal_we and bg_we may be asserted together; both take effect.

Width rules:
- No arithmetic on colour; data is passed through unchanged.
- Palette address is the concatenation {psel, idx}, never a sum.

## Timing
- Latency: fixed 3 cycles from pixel_valid/layer inputs to VGA_*/rgb_valid. A new pixel is accepted every cycle; there is no backpressure.
- pixel_valid=0 propagates as blanking: VGA_* = 0 and rgb_valid = 0 three cycles later.
- Layer inputs are sampled only at the Stage-1 edge and need not be held afterwards.
- Reset asserted mid-stream clears outputs immediately (asynchronous). In-flight pixels are discarded and palette contents are lost.

## Structure
- Shared package `sprite_pkg` holds:
  - the default COLOR_W, IDX_W and PSEL_W constants;
  - the `rgb_t` packed struct {r,g,b};
  - the `TRANSPARENT_IDX` = 0 constant.
  Sprite ROM modules use the same package.
- One sub-module, `palette_ram`: 2^(PSEL_W+IDX_W) × rgb_t, flop-based, async reset, one write port, one registered read-first read port.
- Priority encoding and the frame/blink counter stay inline.

## Test plan
- Reset, then write palette[{0,1}]=FF0000. Drive layer0 hit, idx=1, psel=0 → VGA=FF,00,00 with rgb_valid=1 exactly 3 cycles later.
- Layers 0 and 2 both hit, where layer0 idx=0 and layer2 idx=3, psel=1, palette[7]=00FF00 → 00FF00 (a transparent higher-priority layer is skipped).
- No layer hit with bg=202040 → 202040. With pixel_valid=0 → 000000 and rgb_valid=0.
- BLINK_FRAMES=2, blink_mask=0001, layer0 only hit: pixels in frames 0-1 show the palette colour, frames 2-3 show background, frame 4 shows the palette colour again.
- Write palette[5]=FFFFFF in the same cycle stage 2 reads address 5 (old value 0000FF) → that pixel outputs 0000FF and the next outputs FFFFFF.
- Assert Reset_n low mid-stream for one cycle → VGA_* = 0 and rgb_valid = 0 immediately. After release, a hit with idx≠0 outputs 000000 (palette cleared).

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite/compositor types and default widths.
`default_nettype none

package sprite_pkg;

  localparam int DEFAULT_COLOR_W = 8;
  localparam int DEFAULT_IDX_W   = 2;
  localparam int DEFAULT_PSEL_W  = 2;

  // Colour index that never draws; the layer below (or background) shows through.
  localparam int TRANSPARENT_IDX = 0;

  typedef struct packed {
    logic [DEFAULT_COLOR_W-1:0] r;
    logic [DEFAULT_COLOR_W-1:0] g;
    logic [DEFAULT_COLOR_W-1:0] b;
  } rgb_t;

endpackage

`default_nettype wire

// File: rtl/palette_ram.sv
// palette_ram: flop-based colour table, one write port, one registered read-first read port.
`default_nettype none

module palette_ram
  import sprite_pkg::*;
#(
  parameter int  ADDR_W  = 4,
  parameter type ENTRY_T = rgb_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  ENTRY_T            wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output ENTRY_T            rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  ENTRY_T mem_q [DEPTH];
  ENTRY_T rdata_q;

  // Read samples mem_q before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sprite_compositor.sv
// sprite_compositor: N-layer priority/palette pixel compositor with blinking and a
// programmable background; fixed 3-cycle registered RGB output.
`default_nettype none

module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int IDX_W        = sprite_pkg::DEFAULT_IDX_W,
  parameter int PSEL_W       = sprite_pkg::DEFAULT_PSEL_W,
  parameter int COLOR_W      = sprite_pkg::DEFAULT_COLOR_W,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         pixel_valid,
  input  logic [NUM_LAYERS-1:0]        layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0]  layer_idx,
  input  logic [NUM_LAYERS*PSEL_W-1:0] layer_psel,
  input  logic [NUM_LAYERS-1:0]        blink_mask,
  input  logic                         frame_start,
  input  logic                         pal_we,
  input  logic [PSEL_W+IDX_W-1:0]      pal_waddr,
  input  logic [3*COLOR_W-1:0]         pal_wdata,
  input  logic                         bg_we,
  input  logic [3*COLOR_W-1:0]         bg_wdata,
  output logic [COLOR_W-1:0]           VGA_R,
  output logic [COLOR_W-1:0]           VGA_G,
  output logic [COLOR_W-1:0]           VGA_B,
  output logic                         rgb_valid
);

  localparam int ADDR_W = PSEL_W + IDX_W;
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  pix_t              bg_q;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              blink_phase_q, blink_phase_d;

  logic [NUM_LAYERS-1:0] elig;
  logic [ADDR_W-1:0]     win_addr;
  logic                  win_found;

  logic [ADDR_W-1:0] s1_addr_q;
  logic              s1_use_bg_q;
  logic              s1_valid_q;

  pix_t              pal_rdata;
  pix_t              s2_bg_q;
  logic              s2_use_bg_q;
  logic              s2_valid_q;
  pix_t              s2_color;

  pix_t              vga_q, vga_d;
  logic              rgb_valid_q;

  // ---------------- frame counter / blink phase ----------------
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // ---------------- background register ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bg_q <= '0;
    end else if (bg_we) begin
      bg_q <= pix_t'(bg_wdata);
    end
  end

  // ---------------- stage 1: priority select ----------------
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_elig
    assign elig[k] = layer_hit[k]
                   && (layer_idx[k*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT_IDX))
                   && !(blink_mask[k] && blink_phase_q);
  end

  // Scan from the lowest priority upward so the lowest-numbered eligible layer wins.
  always_comb begin
    win_found = 1'b0;
    win_addr  = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (elig[k]) begin
        win_found = 1'b1;
        win_addr  = {layer_psel[k*PSEL_W +: PSEL_W], layer_idx[k*IDX_W +: IDX_W]};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_addr_q   <= '0;
      s1_use_bg_q <= 1'b0;
      s1_valid_q  <= 1'b0;
    end else begin
      s1_addr_q   <= win_addr;
      s1_use_bg_q <= ~win_found;
      s1_valid_q  <= pixel_valid;
    end
  end

  // ---------------- stage 2: lookup ----------------
  palette_ram #(
    .ADDR_W  (ADDR_W),
    .ENTRY_T (pix_t)
  ) u_palette (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .we_i    (pal_we),
    .waddr_i (pal_waddr),
    .wdata_i (pix_t'(pal_wdata)),
    .raddr_i (s1_addr_q),
    .rdata_o (pal_rdata)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_bg_q     <= '0;
      s2_use_bg_q <= 1'b0;
      s2_valid_q  <= 1'b0;
    end else begin
      s2_bg_q     <= bg_q;
      s2_use_bg_q <= s1_use_bg_q;
      s2_valid_q  <= s1_valid_q;
    end
  end

  assign s2_color = s2_use_bg_q ? s2_bg_q : pal_rdata;

  // ---------------- stage 3: output ----------------
  always_comb begin
    vga_d = '0;
    if (s2_valid_q) begin
      vga_d = s2_color;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vga_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      vga_q       <= vga_d;
      rgb_valid_q <= s2_valid_q;
    end
  end

  assign VGA_R     = vga_q.r;
  assign VGA_G     = vga_q.g;
  assign VGA_B     = vga_q.b;
  assign rgb_valid = rgb_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed-vector bench for sprite_compositor (BLINK_FRAMES=2).
`default_nettype none

module tb_sprite_compositor;

  localparam int NL = 4;
  localparam int IW = 2;
  localparam int PW = 2;
  localparam int CW = 8;

  logic            Clk;
  logic            Reset_n;
  logic            pixel_valid;
  logic [NL-1:0]   layer_hit;
  logic [NL*IW-1:0] layer_idx;
  logic [NL*PW-1:0] layer_psel;
  logic [NL-1:0]   blink_mask;
  logic            frame_start;
  logic            pal_we;
  logic [PW+IW-1:0] pal_waddr;
  logic [3*CW-1:0] pal_wdata;
  logic            bg_we;
  logic [3*CW-1:0] bg_wdata;
  logic [CW-1:0]   VGA_R, VGA_G, VGA_B;
  logic            rgb_valid;

  int vectors;
  int miscompares;

  sprite_compositor #(
    .NUM_LAYERS   (NL),
    .IDX_W        (IW),
    .PSEL_W       (PW),
    .COLOR_W      (CW),
    .BLINK_FRAMES (2)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pixel_valid (pixel_valid),
    .layer_hit   (layer_hit),
    .layer_idx   (layer_idx),
    .layer_psel  (layer_psel),
    .blink_mask  (blink_mask),
    .frame_start (frame_start),
    .pal_we      (pal_we),
    .pal_waddr   (pal_waddr),
    .pal_wdata   (pal_wdata),
    .bg_we       (bg_we),
    .bg_wdata    (bg_wdata),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .rgb_valid   (rgb_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_layers();
    pixel_valid = 1'b0;
    layer_hit   = '0;
    layer_idx   = '0;
    layer_psel  = '0;
  endtask

  task automatic set_layer(input int k, input logic hit, input logic [IW-1:0] idx,
                           input logic [PW-1:0] psel);
    layer_hit[k]         = hit;
    layer_idx[k*IW +: IW] = idx;
    layer_psel[k*PW +: PW] = psel;
  endtask

  task automatic write_pal(input logic [PW+IW-1:0] addr, input logic [3*CW-1:0] data);
    pal_we = 1'b1; pal_waddr = addr; pal_wdata = data;
    tick();
    pal_we = 1'b0;
  endtask

  task automatic write_bg(input logic [3*CW-1:0] data);
    bg_we = 1'b1; bg_wdata = data;
    tick();
    bg_we = 1'b0;
  endtask

  // Present the currently set layer inputs for one cycle, then wait out the latency.
  task automatic push_pixel(input logic valid);
    pixel_valid = valid;
    tick();
    clear_layers();
    tick();
    tick();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    clear_layers();
    blink_mask = '0; frame_start = 1'b0;
    pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    bg_we = 1'b0; bg_wdata = '0;
    tick(); tick();
    vectors++;
    if ({VGA_R, VGA_G, VGA_B, rgb_valid} !== 25'h0) begin
      miscompares++;
      $display("FAIL reset_out: got %h/%b want 000000/0", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
    Reset_n = 1'b1;
    tick(); tick();
    vectors++;
    if (rgb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_valid: got %b want 0", rgb_valid);
    end
  endtask

  task automatic test_latency();
    write_pal(4'h1, 24'hFF0000);
    set_layer(0, 1'b1, 2'd1, 2'd0);
    pixel_valid = 1'b1;
    tick();
    clear_layers();
    tick();
    vectors++;
    if (rgb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_early: got valid %b want 0 after 2 cycles", rgb_valid);
    end
    tick();
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFF0000 || rgb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lat_rgb: got %h/%b want ff0000/1", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
    tick();
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || rgb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_after: got %h/%b want 000000/0", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
  endtask

  task automatic test_transparent_skip();
    write_pal(4'h7, 24'h00FF00);
    set_layer(0, 1'b1, 2'd0, 2'd0);
    set_layer(1, 1'b0, 2'd2, 2'd3);
    set_layer(2, 1'b1, 2'd3, 2'd1);
    push_pixel(1'b1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h00FF00 || rgb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL transp_skip: got %h/%b want 00ff00/1", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
    // Layer 0 opaque must beat layer 2.
    set_layer(0, 1'b1, 2'd1, 2'd0);
    set_layer(2, 1'b1, 2'd3, 2'd1);
    push_pixel(1'b1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFF0000) begin
      miscompares++;
      $display("FAIL priority: got %h want ff0000", {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_background_and_blank();
    write_bg(24'h202040);
    push_pixel(1'b1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h202040 || rgb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bg_nohit: got %h/%b want 202040/1", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
    set_layer(1, 1'b1, 2'd0, 2'd1);
    set_layer(3, 1'b1, 2'd0, 2'd1);
    push_pixel(1'b1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h202040) begin
      miscompares++;
      $display("FAIL bg_alltransp: got %h want 202040", {VGA_R, VGA_G, VGA_B});
    end
    set_layer(0, 1'b1, 2'd1, 2'd0);
    push_pixel(1'b0);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      miscompares++;
      $display("FAIL blank_rgb: got %h want 000000", {VGA_R, VGA_G, VGA_B});
    end
    vectors++;
    if (rgb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL blank_valid: got %b want 0", rgb_valid);
    end
  endtask

  task automatic test_blink();
    logic [23:0] exp_col [5];
    exp_col[0] = 24'hFF0000; exp_col[1] = 24'hFF0000;
    exp_col[2] = 24'h202040; exp_col[3] = 24'h202040;
    exp_col[4] = 24'hFF0000;
    blink_mask = 4'b0001;
    for (int f = 0; f < 5; f++) begin
      if (f != 0) pulse_frame();
      set_layer(0, 1'b1, 2'd1, 2'd0);
      push_pixel(1'b1);
      vectors++;
      if ({VGA_R, VGA_G, VGA_B} !== exp_col[f]) begin
        miscompares++;
        $display("FAIL blink_f%0d: got %h want %h", f, {VGA_R, VGA_G, VGA_B}, exp_col[f]);
      end
      if (f == 2) begin
        // Blinked-out layer 0 uncovers a non-blinking layer 1.
        set_layer(0, 1'b1, 2'd1, 2'd0);
        set_layer(1, 1'b1, 2'd3, 2'd1);
        push_pixel(1'b1);
        vectors++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h00FF00) begin
          miscompares++;
          $display("FAIL blink_uncover: got %h want 00ff00", {VGA_R, VGA_G, VGA_B});
        end
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_write_collision();
    write_pal(4'h5, 24'h0000FF);
    set_layer(0, 1'b1, 2'd1, 2'd1);
    pixel_valid = 1'b1;
    tick();
    pal_we = 1'b1; pal_waddr = 4'h5; pal_wdata = 24'hFFFFFF;
    tick();
    pal_we = 1'b0;
    clear_layers();
    tick();
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0000FF || rgb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_readfirst: got %h/%b want 0000ff/1", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
    tick();
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF || rgb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_newval: got %h/%b want ffffff/1", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
  endtask

  task automatic test_midstream_reset();
    set_layer(0, 1'b1, 2'd1, 2'd1);
    pixel_valid = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF || rgb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_pre: got %h/%b want ffffff/1", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    vectors++;
    if ({VGA_R, VGA_G, VGA_B, rgb_valid} !== 25'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h/%b want 000000/0", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
    tick();
    Reset_n = 1'b1;
    push_pixel(1'b1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || rgb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pal_cleared: got %h/%b want 000000/1", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
    push_pixel(1'b1);
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || rgb_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bg_cleared: got %h/%b want 000000/1", {VGA_R, VGA_G, VGA_B}, rgb_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_latency();
    test_transparent_skip();
    test_background_and_blank();
    test_blink();
    test_write_collision();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
